// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 256-point FFT core: one-shot core config, then per-start
// packing of FFT_LEN ADC samples into the core input and output-stream supervision.
//
// state    | meaning
// ---------+----------------------------------------------------------
// CFG      | issue the one-cycle config pulse to the core
// IDLE     | wait for start; ADC samples are ignored
// LOAD     | capture FFT_LEN samples into the input holding register
// WAIT_OUT | check output bin indices, alarms, and the timeout timer
// DONE     | one-cycle frame_done pulse
module fft_frame_ctrl #(
    parameter int   FFT_LEN  = 256,
    parameter int   LEN_W    = 8,
    parameter int   DATA_W   = 8,
    parameter logic CFG_MODE = 1'b1,
    parameter int   TIMEOUT  = 4096
) (
    input  logic              fft_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ad_valid,
    input  logic [DATA_W-1:0] ad_data,
    output logic              s_tvalid,
    output logic [31:0]       s_tdata,
    output logic              s_tlast,
    input  logic              s_tready,
    output logic              cfg_tvalid,
    output logic              cfg_tdata,
    input  logic              m_tvalid,
    input  logic              m_tlast,
    input  logic [LEN_W-1:0]  m_tuser,
    input  logic [2:0]        alm,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        err,
    output logic [15:0]       drop_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [LEN_W-1:0] IDX_LAST = LEN_W'(FFT_LEN - 1);

    typedef enum logic [2:0] {
        ST_CFG,
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_OUT,
        ST_DONE
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   in_cnt;
    logic [LEN_W-1:0]   out_idx;
    logic               in_all;
    logic [TMR_W-1:0]   tmr;

    logic s_hs;
    logic ad_take;
    logic ad_drop;

    // Once the tlast sample is held, later ADC strobes are neither taken nor counted as drops.
    assign s_hs    = s_tvalid && s_tready;
    assign ad_take = (state == ST_LOAD) && ad_valid && !in_all && (!s_tvalid || s_tready);
    assign ad_drop = (state == ST_LOAD) && ad_valid && !in_all && s_tvalid && !s_tready;

    always_ff @(posedge fft_clk) begin
        if (rst) begin
            state      <= ST_CFG;
            s_tvalid   <= 1'b0;
            s_tdata    <= '0;
            s_tlast    <= 1'b0;
            cfg_tvalid <= 1'b0;
            cfg_tdata  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= '0;
            drop_cnt   <= '0;
            in_cnt     <= '0;
            out_idx    <= '0;
            in_all     <= 1'b0;
            tmr        <= '0;
        end else begin
            cfg_tvalid <= 1'b0;
            cfg_tdata  <= 1'b0;
            frame_done <= 1'b0;

            if (ad_drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (busy && alm != 3'b000)
                err[1] <= 1'b1;

            case (state)
                ST_CFG: begin
                    cfg_tvalid <= 1'b1;
                    cfg_tdata  <= CFG_MODE;
                    state      <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (start) begin
                        err     <= '0;
                        in_cnt  <= '0;
                        out_idx <= '0;
                        in_all  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ad_take) begin
                        s_tvalid <= 1'b1;
                        s_tdata  <= {{(32-DATA_W){1'b0}}, ad_data};
                        s_tlast  <= (in_cnt == IDX_LAST);
                        in_cnt   <= in_cnt + 1'b1;
                        if (in_cnt == IDX_LAST)
                            in_all <= 1'b1;
                    end else if (s_hs) begin
                        s_tvalid <= 1'b0;
                        s_tlast  <= 1'b0;
                    end
                    if (s_hs && s_tlast) begin
                        tmr   <= TMR_W'(TIMEOUT - 1);
                        state <= ST_WAIT_OUT;
                    end
                end
                ST_WAIT_OUT: begin
                    if (m_tvalid) begin
                        if (m_tuser != out_idx || (m_tlast && out_idx != IDX_LAST))
                            err[0] <= 1'b1;
                        out_idx <= out_idx + 1'b1;
                    end
                    // A completing beat wins over a simultaneous timer expiry.
                    if (m_tvalid && m_tlast) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= ST_DONE;
                    end else if (tmr == '0) begin
                        err[2] <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_CFG;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed-sequence bench for fft_frame_ctrl with randomized ready/valid traffic
// checked against a transaction-level model of the input register and drop counter.
module tb_fft_frame_ctrl;

    localparam int FFT_LEN = 256;
    localparam int TIMEOUT = 4096;

    logic        fft_clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ad_valid;
    logic [7:0]  ad_data;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        cfg_tvalid;
    logic        cfg_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [7:0]  m_tuser;
    logic [2:0]  alm;
    logic        busy;
    logic        frame_done;
    logic [2:0]  err;
    logic [15:0] drop_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int m_drops = 0;

    always #5 fft_clk = ~fft_clk;

    fft_frame_ctrl dut (
        .fft_clk    (fft_clk),
        .rst        (rst),
        .start      (start),
        .ad_valid   (ad_valid),
        .ad_data    (ad_data),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tdata  (cfg_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .alm        (alm),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change after the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(posedge fft_clk);
        @(negedge fft_clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_flags"}, {26'd0, s_tvalid, s_tlast, cfg_tvalid, cfg_tdata, busy, frame_done}, 32'd0);
        chk({tag, "_tdata"}, s_tdata, 32'd0);
        chk({tag, "_err"}, {29'd0, err}, 32'd0);
        chk({tag, "_drop"}, {16'd0, drop_cnt}, 32'd0);
    endtask

    // Start a frame and feed samples until the tlast beat handshakes (or abort_at samples taken).
    task automatic load_frame(input int rdy_pct, input int vld_pct, input bit ramp,
                              input int stall_at, input bit do_alm, input int abort_at,
                              output int ncyc);
        bit          full, last_m, all_in, done, hs, acc, drp;
        logic [31:0] dat;
        int          n_acc, n_hs;
        full = 0; last_m = 0; all_in = 0; done = 0; dat = 0; n_acc = 0; n_hs = 0; ncyc = 0;

        start = 1'b1; ad_valid = 1'b1; ad_data = 8'hEE; s_tready = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_overlap_tvalid", {31'd0, s_tvalid}, 32'd0);

        while (!done && ncyc < 20000) begin
            if (abort_at != 0 && n_acc == abort_at) return;
            ad_valid = ramp ? 1'b1 : ($urandom_range(99) < vld_pct);
            ad_data  = ramp ? 8'(n_acc) : 8'($urandom);
            s_tready = ($urandom_range(99) < rdy_pct);
            if (stall_at != 0 && ncyc >= stall_at && ncyc < stall_at + 5) s_tready = 1'b0;
            alm = (do_alm && ncyc == 20) ? 3'b010 : 3'b000;

            hs  = full && s_tready;
            acc = ad_valid && !all_in && (!full || s_tready);
            drp = ad_valid && !all_in && full && !s_tready;
            if (hs) n_hs++;
            if (hs && last_m) done = 1;
            if (acc) begin
                dat    = {24'd0, ad_data};
                last_m = (n_acc == FFT_LEN - 1);
                n_acc++;
                all_in = (n_acc == FFT_LEN);
                full   = 1;
            end else if (hs) begin
                full = 0;
            end
            if (drp && m_drops < 65535) m_drops++;

            tick();
            ncyc++;
            chk("s_tvalid", {31'd0, s_tvalid}, {31'd0, full});
            if (full) begin
                chk("s_tdata", s_tdata, dat);
                chk("s_tlast", {31'd0, s_tlast}, {31'd0, last_m});
            end
            chk("drop_cnt", {16'd0, drop_cnt}, m_drops);
            chk("load_busy", {31'd0, busy}, 32'd1);
        end
        alm = 3'b000; ad_valid = 1'b0; s_tready = 1'b0;
        chk("load_handshakes", n_hs, FFT_LEN);
        chk("load_complete", {31'd0, done}, 32'd1);
    endtask

    // Return one output frame; skip >= 0 omits that bin index from the stream.
    task automatic out_frame(input int skip, input int gap_pct, input logic [2:0] exp_err);
        int gaps;
        for (int t = 0; t < FFT_LEN; t++) begin
            if (t == skip) continue;
            gaps = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
            repeat (gaps) begin
                m_tvalid = 1'b0; m_tlast = 1'b0;
                tick();
                chk("gap_done", {31'd0, frame_done}, 32'd0);
            end
            m_tvalid = 1'b1;
            m_tuser  = 8'(t);
            m_tlast  = (t == FFT_LEN - 1);
            tick();
            if (t == FFT_LEN - 1) begin
                chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
                chk("done_busy", {31'd0, busy}, 32'd0);
                chk("done_err", {29'd0, err}, {29'd0, exp_err});
            end else begin
                chk("beat_busy", {31'd0, busy}, 32'd1);
            end
        end
        m_tvalid = 1'b0; m_tlast = 1'b0;
        tick();
        chk("frame_done_width", {31'd0, frame_done}, 32'd0);
        chk("err_sticky", {29'd0, err}, {29'd0, exp_err});
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int ncyc, d0, n, fd_seen;
        rst = 1'b1; start = 1'b0; ad_valid = 1'b0; ad_data = 8'h00; s_tready = 1'b0;
        m_tvalid = 1'b0; m_tlast = 1'b0; m_tuser = 8'h00; alm = 3'b000;

        // Reset and config pulse; a start during CFG must be ignored
        repeat (3) tick();
        chk_quiet("reset");
        rst = 1'b0; start = 1'b1;
        tick();
        chk("cfg_tvalid_pulse", {31'd0, cfg_tvalid}, 32'd1);
        chk("cfg_tdata", {31'd0, cfg_tdata}, 32'd1);
        chk("cfg_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        tick();
        chk_quiet("post_cfg");

        // Samples in IDLE are neither captured nor counted
        ad_valid = 1'b1; ad_data = 8'h5A;
        repeat (4) tick();
        chk_quiet("idle_samples");

        // Clean ramp frame at full throughput
        load_frame(100, 100, 1'b1, 0, 1'b0, 0, ncyc);
        chk("throughput_cycles", ncyc, FFT_LEN + 1);
        chk("clean_drop", {16'd0, drop_cnt}, 32'd0);
        out_frame(-1, 0, 3'b000);

        // Backpressure: 5 stalled cycles with a full register
        d0 = m_drops;
        load_frame(100, 100, 1'b1, 50, 1'b0, 0, ncyc);
        chk("bp_drop_delta", {16'd0, drop_cnt} - d0, 32'd5);
        out_frame(-1, 30, 3'b000);

        // Random traffic, output stream skips bin 10
        load_frame(50, 70, 1'b0, 0, 1'b0, 0, ncyc);
        out_frame(10, 20, 3'b001);

        // No output beats: timeout after TIMEOUT cycles in WAIT_OUT
        load_frame(60, 60, 1'b0, 0, 1'b0, 0, ncyc);
        n = 0; fd_seen = 0;
        while (busy && n < TIMEOUT + 100) begin
            tick();
            n++;
            if (frame_done) fd_seen = 1;
        end
        chk("timeout_cycles", n, TIMEOUT);
        chk("timeout_err", {29'd0, err}, 32'b100);
        chk("timeout_no_done", fd_seen, 0);
        tick();
        chk("timeout_idle_busy", {31'd0, busy}, 32'd0);

        // Alarm during LOAD
        load_frame(70, 80, 1'b0, 0, 1'b1, 0, ncyc);
        out_frame(-1, 10, 3'b010);

        // Reset in the middle of LOAD, then a full frame
        load_frame(100, 100, 1'b1, 0, 1'b0, 100, ncyc);
        chk("mid_tvalid_before", {31'd0, s_tvalid}, 32'd1);
        rst = 1'b1; ad_valid = 1'b1;
        tick();
        m_drops = 0;
        chk_quiet("mid_reset");
        rst = 1'b0; ad_valid = 1'b0;
        tick();
        chk("mid_cfg_reissue", {31'd0, cfg_tvalid}, 32'd1);
        tick();
        chk("mid_cfg_end", {31'd0, cfg_tvalid}, 32'd0);
        load_frame(100, 100, 1'b1, 0, 1'b0, 0, ncyc);
        chk("mid_full_frame_cycles", ncyc, FFT_LEN + 1);
        out_frame(-1, 0, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
